// File: rtl/npu_pkg.sv
// Shared definitions for the NPU layer sequencer: op codes, descriptor
// layout (word count, stride, field offsets) and FSM state encoding.
package npu_pkg;

    // NPU operating modes driven on o_op_mode
    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_POOL = 2'b01;
    localparam logic [1:0] OP_FC   = 2'b10;
    localparam logic [1:0] OP_CONV = 2'b11;

    // Descriptor geometry: five 32-bit words per layer, packed back to back
    localparam int DESC_WORDS = 5;
    localparam int DESC_BYTES = 20;

    // Word 0: image geometry and op mode
    localparam int W0_IMG_W_LSB  = 24;
    localparam int W0_IMG_H_LSB  = 16;
    localparam int W0_IMG_CH_LSB = 8;
    localparam int W0_OP_LSB     = 0;
    // Word 1: image slice geometry
    localparam int W1_SLC_W_LSB  = 24;
    localparam int W1_SLC_H_LSB  = 16;
    localparam int W1_SLC_N_LSB  = 8;
    // Word 2: filter geometry
    localparam int W2_FLT_W_LSB  = 24;
    localparam int W2_FLT_H_LSB  = 16;
    localparam int W2_FLT_CH_LSB = 8;
    localparam int W2_FLT_N_LSB  = 0;
    // Word 3: filter slice geometry
    localparam int W3_SLC_W_LSB  = 24;
    localparam int W3_SLC_H_LSB  = 16;
    localparam int W3_SLC_N_LSB  = 8;
    // Word 4: output depth
    localparam int W4_DEPTH_LSB  = 0;
    localparam int DEPTH_W       = 12;

    // Sequencer FSM encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ARM   = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_TERM  = 3'd6;

    // Decoded layer configuration held stable while the layer executes
    typedef struct packed {
        logic [1:0]         op_mode;
        logic [7:0]         img_w;
        logic [7:0]         img_h;
        logic [7:0]         img_ch;
        logic [7:0]         img_sw;
        logic [7:0]         img_sh;
        logic [7:0]         img_sn;
        logic [7:0]         flt_w;
        logic [7:0]         flt_h;
        logic [7:0]         flt_ch;
        logic [7:0]         flt_n;
        logic [7:0]         flt_sw;
        logic [7:0]         flt_sh;
        logic [7:0]         flt_sn;
        logic [DEPTH_W-1:0] out_depth;
    } desc_cfg_t;

endpackage

// File: rtl/npu_desc_fetch.sv
// Descriptor fetch counter: issues the five word reads of one layer on
// consecutive cycles and flags which word is returning each cycle.
module npu_desc_fetch
    import npu_pkg::*;
#(
    parameter int DESC_BASE_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_n_reset,
    input  logic                   i_active,
    input  logic                   i_abort,
    input  logic [DESC_BASE_W-1:0] i_base,
    input  logic [7:0]             i_layer,
    output logic                   o_en,
    output logic [DESC_BASE_W-1:0] o_addr,
    output logic                   o_cap_vld,
    output logic [2:0]             o_cap_k,
    output logic                   o_last
);

    localparam logic [2:0] LAST_CNT = 3'(DESC_WORDS);

    logic [2:0]             cnt_q, cnt_d;
    logic [DESC_BASE_W-1:0] layer_off;

    // Counter runs 0..5 while the FSM sits in FETCH; 0..4 issue, 1..5 capture
    always_comb begin
        cnt_d = 3'd0;
        if (i_active && !i_abort && cnt_q != LAST_CNT) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    // Issue/capture counter register
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Address arithmetic wraps naturally at DESC_BASE_W bits
    assign layer_off = DESC_BASE_W'(i_layer) * DESC_BASE_W'(DESC_BYTES);
    assign o_en      = i_active && (cnt_q < LAST_CNT);
    assign o_addr    = o_en ? (i_base + layer_off + DESC_BASE_W'({cnt_q, 2'b00}))
                            : '0;
    // A read returning in an abort cycle is dropped
    assign o_cap_vld = i_active && !i_abort && (cnt_q != 3'd0);
    assign o_cap_k   = cnt_q - 3'd1;
    assign o_last    = i_active && (cnt_q == LAST_CNT);

endmodule

// File: rtl/npu_layer_sequencer.sv
// NPU layer sequencer: walks a table of per-layer descriptors, programs the
// NPU configuration for each layer, runs it and hands off to the next.
module npu_layer_sequencer
    import npu_pkg::*;
#(
    parameter int MAX_LAYERS  = 16,
    parameter int DESC_BASE_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_n_reset,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [7:0]             i_num_layers,
    input  logic [DESC_BASE_W-1:0] i_desc_base,
    output logic                   o_en_desc_ram,
    output logic [DESC_BASE_W-1:0] o_desc_ram_addr,
    input  logic [31:0]            i_desc_ram_data,
    output logic [1:0]             o_op_mode,
    output logic                   o_output_layer,
    output logic                   o_terminate,
    input  logic                   i_npu_done,
    output logic [7:0]             o_image_width,
    output logic [7:0]             o_image_height,
    output logic [7:0]             o_image_channel,
    output logic [7:0]             o_image_slice_width,
    output logic [7:0]             o_image_slice_height,
    output logic [7:0]             o_image_slice_number,
    output logic [7:0]             o_filter_width,
    output logic [7:0]             o_filter_height,
    output logic [7:0]             o_filter_channel,
    output logic [7:0]             o_filter_number,
    output logic [7:0]             o_filter_slice_width,
    output logic [7:0]             o_filter_slice_height,
    output logic [7:0]             o_filter_slice_number,
    output logic [11:0]            o_output_depth,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic [7:0]             o_layer_idx
);

    localparam logic [8:0] MAX_L = 9'(MAX_LAYERS);

    logic [2:0]             state_q, state_d;
    logic [7:0]             layer_q, layer_d;
    logic [7:0]             num_q, num_d;
    logic [DESC_BASE_W-1:0] base_q, base_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    desc_cfg_t              cfg_q, cfg_d;

    logic       start_ok;
    logic       fetch_cap_vld, fetch_last;
    logic [2:0] fetch_cap_k;

    assign start_ok = (i_num_layers != 8'd0) && ({1'b0, i_num_layers} <= MAX_L);

    npu_desc_fetch #(.DESC_BASE_W(DESC_BASE_W)) u_fetch (
        .i_clk     (i_clk),
        .i_n_reset (i_n_reset),
        .i_active  (state_q == S_FETCH),
        .i_abort   (i_abort),
        .i_base    (base_q),
        .i_layer   (layer_q),
        .o_en      (o_en_desc_ram),
        .o_addr    (o_desc_ram_addr),
        .o_cap_vld (fetch_cap_vld),
        .o_cap_k   (fetch_cap_k),
        .o_last    (fetch_last)
    );

    // Sequencer next-state: layer walk, sticky done/error, abort override
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        num_d   = num_q;
        base_d  = base_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (start_ok) begin
                        state_d = S_FETCH;
                        layer_d = 8'd0;
                        num_d   = i_num_layers;
                        base_d  = i_desc_base;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FETCH: if (fetch_last) state_d = S_ARM;
            S_ARM: begin
                if (cfg_q.op_mode == OP_IDLE) begin
                    err_d   = 1'b1;
                    state_d = S_TERM;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   if (i_npu_done) state_d = S_DRAIN;
            S_DRAIN: if (!i_npu_done) state_d = S_NEXT;
            S_NEXT: begin
                layer_d = layer_q + 8'd1;
                state_d = (layer_q + 8'd1 == num_q) ? S_TERM : S_FETCH;
            end
            S_TERM: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort beats every other event; TERM already on its way out
        if (i_abort && state_q != S_IDLE) begin
            err_d = 1'b1;
            if (state_q != S_TERM) begin
                state_d = S_TERM;
                layer_d = layer_q;
            end
        end
    end

    // Descriptor word k lands in its config fields the cycle after issue
    always_comb begin
        cfg_d = cfg_q;
        if (fetch_cap_vld) begin
            case (fetch_cap_k)
                3'd0: begin
                    cfg_d.img_w   = i_desc_ram_data[W0_IMG_W_LSB +: 8];
                    cfg_d.img_h   = i_desc_ram_data[W0_IMG_H_LSB +: 8];
                    cfg_d.img_ch  = i_desc_ram_data[W0_IMG_CH_LSB +: 8];
                    cfg_d.op_mode = i_desc_ram_data[W0_OP_LSB +: 2];
                end
                3'd1: begin
                    cfg_d.img_sw = i_desc_ram_data[W1_SLC_W_LSB +: 8];
                    cfg_d.img_sh = i_desc_ram_data[W1_SLC_H_LSB +: 8];
                    cfg_d.img_sn = i_desc_ram_data[W1_SLC_N_LSB +: 8];
                end
                3'd2: begin
                    cfg_d.flt_w  = i_desc_ram_data[W2_FLT_W_LSB +: 8];
                    cfg_d.flt_h  = i_desc_ram_data[W2_FLT_H_LSB +: 8];
                    cfg_d.flt_ch = i_desc_ram_data[W2_FLT_CH_LSB +: 8];
                    cfg_d.flt_n  = i_desc_ram_data[W2_FLT_N_LSB +: 8];
                end
                3'd3: begin
                    cfg_d.flt_sw = i_desc_ram_data[W3_SLC_W_LSB +: 8];
                    cfg_d.flt_sh = i_desc_ram_data[W3_SLC_H_LSB +: 8];
                    cfg_d.flt_sn = i_desc_ram_data[W3_SLC_N_LSB +: 8];
                end
                3'd4: cfg_d.out_depth = i_desc_ram_data[W4_DEPTH_LSB +: DEPTH_W];
                default: ;
            endcase
        end
    end

    // State, layer bookkeeping and configuration registers
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state_q <= S_IDLE;
            layer_q <= 8'd0;
            num_q   <= 8'd0;
            base_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            num_q   <= num_d;
            base_q  <= base_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cfg_q   <= cfg_d;
        end
    end

    // NPU only sees a live op mode in RUN; ARM and DRAIN keep it parked
    assign o_op_mode      = (state_q == S_RUN) ? cfg_q.op_mode : OP_IDLE;
    assign o_output_layer = (state_q == S_RUN) && (layer_q == num_q - 8'd1);
    assign o_terminate    = (state_q == S_TERM);
    assign o_busy         = (state_q != S_IDLE);
    assign o_done         = done_q;
    assign o_error        = err_q;
    assign o_layer_idx    = layer_q;

    assign o_image_width         = cfg_q.img_w;
    assign o_image_height        = cfg_q.img_h;
    assign o_image_channel       = cfg_q.img_ch;
    assign o_image_slice_width   = cfg_q.img_sw;
    assign o_image_slice_height  = cfg_q.img_sh;
    assign o_image_slice_number  = cfg_q.img_sn;
    assign o_filter_width        = cfg_q.flt_w;
    assign o_filter_height       = cfg_q.flt_h;
    assign o_filter_channel      = cfg_q.flt_ch;
    assign o_filter_number       = cfg_q.flt_n;
    assign o_filter_slice_width  = cfg_q.flt_sw;
    assign o_filter_slice_height = cfg_q.flt_sh;
    assign o_filter_slice_number = cfg_q.flt_sn;
    assign o_output_depth        = cfg_q.out_depth;

endmodule

// File: tb/tb_npu_layer_sequencer.sv
// Directed bench for npu_layer_sequencer with a descriptor RAM model and an
// address scoreboard fed at start and drained on every RAM enable.
module tb_npu_layer_sequencer;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        start = 1'b0, abort = 1'b0, npu_done = 1'b0;
    logic [7:0]  num = 8'd0;
    logic [31:0] base = 32'd0;
    logic [31:0] rdata = 32'd0;

    logic        en;
    logic [31:0] addr;
    logic [1:0]  op_mode;
    logic        out_layer, term, busy, done, error;
    logic [7:0]  img_w, img_h, img_ch, img_sw, img_sh, img_sn;
    logic [7:0]  flt_w, flt_h, flt_ch, flt_n, flt_sw, flt_sh, flt_sn;
    logic [11:0] depth;
    logic [7:0]  layer_idx;

    int checks = 0, failures = 0;
    int term_cnt = 0, en_cnt = 0, run_cnt = 0;
    int snap;
    logic [31:0] ram [logic [31:0]];
    logic [31:0] exp_q [$];

    npu_layer_sequencer #(.MAX_LAYERS(16), .DESC_BASE_W(32)) dut (
        .i_clk(clk), .i_n_reset(rst_n), .i_start(start), .i_abort(abort),
        .i_num_layers(num), .i_desc_base(base),
        .o_en_desc_ram(en), .o_desc_ram_addr(addr), .i_desc_ram_data(rdata),
        .o_op_mode(op_mode), .o_output_layer(out_layer), .o_terminate(term),
        .i_npu_done(npu_done),
        .o_image_width(img_w), .o_image_height(img_h), .o_image_channel(img_ch),
        .o_image_slice_width(img_sw), .o_image_slice_height(img_sh),
        .o_image_slice_number(img_sn),
        .o_filter_width(flt_w), .o_filter_height(flt_h), .o_filter_channel(flt_ch),
        .o_filter_number(flt_n), .o_filter_slice_width(flt_sw),
        .o_filter_slice_height(flt_sh), .o_filter_slice_number(flt_sn),
        .o_output_depth(depth),
        .o_busy(busy), .o_done(done), .o_error(error), .o_layer_idx(layer_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Descriptor RAM: read data one cycle after enable
    always @(posedge clk) begin
        if (en) rdata <= ram.exists(addr) ? ram[addr] : 32'h0;
    end

    // Scoreboard drain and event counters
    always @(negedge clk) begin
        if (term) term_cnt++;
        if (op_mode != 2'b00) run_cnt++;
        if (en) begin
            en_cnt++;
            if (exp_q.size() == 0) chk("unexpected_ram_en", {31'd0, en}, 32'd0);
            else chk("ram_addr", addr, exp_q.pop_front());
        end
    end

    task automatic put_desc(input logic [31:0] b, input int l, input logic [31:0] w0,
                            input logic [31:0] w1, input logic [31:0] w2,
                            input logic [31:0] w3, input logic [31:0] w4);
        logic [31:0] a;
        a = b + 32'(20 * l);
        ram[a] = w0; ram[a + 32'd4] = w1; ram[a + 32'd8] = w2;
        ram[a + 32'd12] = w3; ram[a + 32'd16] = w4;
    endtask

    task automatic push_addrs(input logic [31:0] b, input int n);
        for (int l = 0; l < n; l++)
            for (int k = 0; k < 5; k++)
                exp_q.push_back(b + 32'(20 * l) + 32'(4 * k));
    endtask

    task automatic do_start(input logic [31:0] b, input logic [7:0] n);
        @(posedge clk); #1;
        base = b; num = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for RUN, then check the live configuration against the table
    task automatic check_run(input logic [31:0] b, input int l, input logic last);
        logic [31:0] a, w0, w1, w2, w3, w4;
        logic found;
        a = b + 32'(20 * l);
        w0 = ram[a]; w1 = ram[a + 32'd4]; w2 = ram[a + 32'd8];
        w3 = ram[a + 32'd12]; w4 = ram[a + 32'd16];
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (op_mode != 2'b00) found = 1'b1;
        end
        chk("run_reached", {31'd0, found}, 32'd1);
        chk("op_mode", op_mode, w0[1:0]);
        chk("img_w", img_w, w0[31:24]);
        chk("img_ch", img_ch, w0[15:8]);
        chk("img_slice_n", img_sn, w1[15:8]);
        chk("flt_num", flt_n, w2[7:0]);
        chk("flt_w", flt_w, w2[31:24]);
        chk("flt_slice_w", flt_sw, w3[31:24]);
        chk("out_depth", depth, w4[11:0]);
        chk("layer_idx", layer_idx, l);
        chk("output_layer", out_layer, last);
    endtask

    task automatic run_layer(input logic [31:0] b, input int l, input logic last);
        check_run(b, l, last);
        npu_done = 1'b1;
        @(negedge clk);
        chk("drain_op_mode", op_mode, 0);
        chk("drain_busy", busy, 1);
        npu_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 60 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        chk(tag, {31'd0, idle}, 32'd1);
    endtask

    initial begin
        put_desc(32'h100, 0, 32'h1C1C0103, 32'h0E0E0400, 32'h03030110, 32'h03030100, 32'h00000010);
        put_desc(32'h200, 0, 32'h0A0B0C02, 32'h01020300, 32'h01010A40, 32'h01010200, 32'h00000ABC);
        put_desc(32'h200, 1, 32'h10100401, 32'h08080200, 32'h02020401, 32'h02020100, 32'h00000040);
        put_desc(32'h200, 2, 32'h07070803, 32'h07070100, 32'h05050810, 32'h05050300, 32'h00000FFF);
        put_desc(32'h300, 0, 32'h10100100, 32'h0, 32'h0, 32'h0, 32'h0);
        put_desc(32'hFFFFFFF0, 0, 32'h08080201, 32'h04040200, 32'h02020208, 32'h01010400, 32'h00000123);

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_op_mode", op_mode, 0);
        chk("rst_ram_en", en, 0);
        chk("rst_terminate", term, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_layer_idx", layer_idx, 0);
        chk("rst_img_w", img_w, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single CONV layer at 0x100
        term_cnt = 0;
        push_addrs(32'h100, 1);
        do_start(32'h100, 8'd1);
        run_layer(32'h100, 0, 1'b1);
        wait_idle("t1_idle");
        chk("t1_img_w_28", img_w, 8'd28);
        chk("t1_term_cnt", term_cnt, 1);
        chk("t1_done", done, 1);
        chk("t1_error", error, 0);
        chk("t1_sb_empty", exp_q.size(), 0);

        // Too many layers rejected
        term_cnt = 0; snap = en_cnt;
        do_start(32'h100, 8'd17);
        repeat (8) @(negedge clk);
        chk("n17_error", error, 1);
        chk("n17_busy", busy, 0);
        chk("n17_no_en", en_cnt, snap);
        chk("n17_no_term", term_cnt, 0);

        // Three layers FC / POOL / CONV
        term_cnt = 0;
        push_addrs(32'h200, 3);
        do_start(32'h200, 8'd3);
        run_layer(32'h200, 0, 1'b0);
        run_layer(32'h200, 1, 1'b0);
        run_layer(32'h200, 2, 1'b1);
        wait_idle("t3_idle");
        chk("t3_term_cnt", term_cnt, 1);
        chk("t3_done", done, 1);
        chk("t3_error_cleared", error, 0);
        chk("t3_sb_empty", exp_q.size(), 0);

        // Zero layers rejected
        term_cnt = 0; snap = en_cnt;
        do_start(32'h100, 8'd0);
        repeat (8) @(negedge clk);
        chk("n0_error", error, 1);
        chk("n0_no_en", en_cnt, snap);
        chk("n0_no_term", term_cnt, 0);

        // Address wrap across 2^32
        term_cnt = 0;
        push_addrs(32'hFFFFFFF0, 1);
        do_start(32'hFFFFFFF0, 8'd1);
        run_layer(32'hFFFFFFF0, 0, 1'b1);
        wait_idle("wrap_idle");
        chk("wrap_sb_empty", exp_q.size(), 0);
        chk("wrap_done", done, 1);

        // Abort during RUN of layer 1 of 3, coincident with npu_done
        term_cnt = 0;
        push_addrs(32'h200, 2);
        do_start(32'h200, 8'd3);
        run_layer(32'h200, 0, 1'b0);
        check_run(32'h200, 1, 1'b0);
        abort = 1'b1; npu_done = 1'b1;
        @(negedge clk);
        abort = 1'b0; npu_done = 1'b0;
        chk("abort_terminate", term, 1);
        chk("abort_op_mode", op_mode, 0);
        chk("abort_error", error, 1);
        @(negedge clk);
        chk("abort_term_one", term, 0);
        chk("abort_done", done, 1);
        chk("abort_idle", busy, 0);
        chk("abort_term_cnt", term_cnt, 1);
        chk("abort_sb_empty", exp_q.size(), 0);

        // Descriptor with op_mode 00 fails in ARM
        term_cnt = 0; snap = run_cnt;
        push_addrs(32'h300, 1);
        do_start(32'h300, 8'd1);
        wait_idle("arm_idle");
        chk("arm_error", error, 1);
        chk("arm_done", done, 1);
        chk("arm_term_cnt", term_cnt, 1);
        chk("arm_never_run", run_cnt, snap);

        // npu_done held 4 cycles: stays in DRAIN, no next fetch
        term_cnt = 0;
        push_addrs(32'h200, 2);
        do_start(32'h200, 8'd2);
        check_run(32'h200, 0, 1'b0);
        npu_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_op_mode", op_mode, 0);
            chk("hold_no_en", en, 0);
            chk("hold_layer", layer_idx, 0);
        end
        npu_done = 1'b0;
        run_layer(32'h200, 1, 1'b1);
        wait_idle("hold_idle");
        chk("hold_term_cnt", term_cnt, 1);
        chk("hold_sb_empty", exp_q.size(), 0);

        // Asynchronous reset mid-RUN with npu_done high
        push_addrs(32'h100, 1);
        do_start(32'h100, 8'd1);
        check_run(32'h100, 0, 1'b1);
        npu_done = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_op_mode", op_mode, 0);
        chk("mid_rst_out_layer", out_layer, 0);
        chk("mid_rst_img_w", img_w, 0);
        chk("mid_rst_depth", depth, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_error", error, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; npu_done = 1'b0;
        term_cnt = 0;
        push_addrs(32'h100, 1);
        do_start(32'h100, 8'd1);
        run_layer(32'h100, 0, 1'b1);
        wait_idle("post_rst_idle");
        chk("post_rst_done", done, 1);
        chk("post_rst_term_cnt", term_cnt, 1);
        chk("post_rst_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npu_layer_sequencer.md
NPU_LAYER_SEQUENCER -- requirements
Module: npu_layer_sequencer

Interface
REQ-001 SHALL have parameter MAX_LAYERS, default 16, meaning largest accepted layer count.
REQ-002 SHALL have parameter DESC_BASE_W, default 32, meaning descriptor RAM byte-address width.
REQ-003 SHALL have port i_clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port i_n_reset  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports i_start  in  1  one-cycle start pulse; i_abort  in  1  one-cycle abort pulse.
REQ-006 SHALL have ports i_num_layers  in  8  layer count; i_desc_base  in  DESC_BASE_W  byte address of descriptor 0.
REQ-007 SHALL have ports o_en_desc_ram  out  1; o_desc_ram_addr  out  DESC_BASE_W; i_desc_ram_data  in  32 (read data valid one cycle after enable).
REQ-008 SHALL have ports o_op_mode  out  2; o_output_layer  out  1; o_terminate  out  1; i_npu_done  in  1.
REQ-009 SHALL have ports o_image_{width,height,channel,slice_width,slice_height,slice_number}  out  8 each.
REQ-010 SHALL have ports o_filter_{width,height,channel,number,slice_width,slice_height,slice_number}  out  8 each; o_output_depth  out  12.
REQ-011 SHALL have ports o_busy, o_done, o_error  out  1 each; o_layer_idx  out  8.

Function
REQ-012 Descriptor: 5 words at i_desc_base + 20*layer + 4*k. w0=[31:24]img_w,[23:16]img_h,[15:8]img_ch,[1:0]op_mode; w1=[31:8]img slice w/h/n; w2=[31:0]flt w/h/ch/num; w3=[31:8]flt slice w/h/n; w4=[11:0]output_depth.
REQ-013 States SHALL be IDLE, FETCH, ARM, RUN, DRAIN, NEXT, TERM.
REQ-014 IDLE: i_start with 1<=i_num_layers<=MAX_LAYERS -> FETCH, layer_idx=0, o_done/o_error cleared; otherwise i_start sets o_error, stays IDLE.
REQ-015 FETCH: o_en_desc_ram high 5 consecutive cycles, k=0..4; word k captured into config registers the cycle after issue; FETCH lasts 6 cycles, then ARM.
REQ-016 Config outputs SHALL change only in FETCH and hold stable through ARM/RUN/DRAIN.
REQ-017 ARM: one cycle, o_op_mode still 00; captured op_mode==00 sets o_error -> TERM; else -> RUN.
REQ-018 RUN: o_op_mode = descriptor op_mode; o_output_layer high iff layer_idx==i_num_layers-1 (count latched at start); i_npu_done high -> DRAIN.
REQ-019 DRAIN: o_op_mode=00; wait i_npu_done low, then NEXT.
REQ-020 NEXT: layer_idx+1; if equal latched count -> TERM, else FETCH.
REQ-021 TERM: o_terminate high exactly one cycle, o_done set (sticky until next accepted start), -> IDLE.
REQ-022 i_abort in any non-IDLE state SHALL force TERM next cycle, o_op_mode=00, o_error set, pending RAM read discarded; ignored in IDLE.
REQ-023 i_start while o_busy SHALL be ignored; i_abort and i_npu_done in same cycle: abort wins.
REQ-024 o_busy high in every state except IDLE; o_layer_idx = current layer_idx.
REQ-025 Address arithmetic SHALL be DESC_BASE_W bits, wrapping modulo 2^DESC_BASE_W.

Reset
REQ-026 Reset SHALL force IDLE, all outputs 0 (o_op_mode=00, config=0, layer_idx=0, flags 0) asynchronously, including mid-layer.
REQ-027 Deassertion SHALL be synchronised externally; block needs no reset-release cycle.

Structure
REQ-028 Shared package npu_pkg SHALL hold op_mode codes (IDLE 00, POOL 01, FC 10, CONV 11), DESC_WORDS=5, DESC_BYTES=20, word bit-field offsets, state encoding.
REQ-029 One sub-module npu_desc_fetch SHALL implement the 5-word issue/capture counter (REQ-015); FSM stays in top.

Verification
REQ-030 1 layer CONV, base 0x100, desc w0=0x1C1C0103 -> addrs 0x100..0x110, RUN op_mode=11, img_w=28, o_output_layer=1, done pulse -> one o_terminate, o_done=1.
REQ-031 3 layers FC/POOL/CONV -> addrs base+0/20/40, o_output_layer only on layer 2, op_mode 00 in each DRAIN, o_layer_idx 0,1,2.
REQ-032 i_num_layers=0 and =17 -> o_error=1, no RAM enable, no o_terminate.
REQ-033 i_abort during RUN of layer 1 of 3 -> next cycle TERM, op_mode 00, o_terminate 1 cycle, o_error=1, o_done=1.
REQ-034 i_n_reset low in RUN with i_npu_done held high -> all outputs 0 immediately; after release, new start runs cleanly from layer 0.
REQ-035 i_npu_done held high 4 cycles -> sequencer stays in DRAIN, no second layer fetch until low.
